// File: rtl/key_event_arb.sv
// key_event_arb: latches key press pulses as pending, grants them round-robin
// into a show-ahead event FIFO and tags same-key repeats inside a cycle window
// as double presses. Dropped presses raise a sticky overflow flag.

// Per-key pending latch. A press that lands while the key is still pending and
// not being granted this cycle is reported as a drop.
module key_pend_lane (
    input  logic clk,
    input  logic rst,
    input  logic flag,
    input  logic gnt,
    output logic pend,
    output logic drop
);

    assign drop = flag & pend & ~gnt;

    // A grant and a new press in the same cycle leave the latch set for the new press
    always_ff @(posedge clk) begin
        if (rst) pend <= 1'b0;
        else     pend <= flag | (pend & ~gnt);
    end

endmodule

module key_event_arb #(
    parameter  int N_KEYS  = 4,
    parameter  int DEPTH   = 4,
    parameter  int DBL_CYC = 15_000_000,
    localparam int KW      = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_flag,
    input  logic              clr_ovf,
    input  logic              ev_ready,
    output logic              ev_valid,
    output logic [KW-1:0]     ev_key,
    output logic              ev_dbl,
    output logic [N_KEYS-1:0] pending,
    output logic              overflow
);

    localparam int WW = $clog2(DBL_CYC + 1);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [KW-1:0] key;
        logic          dbl;
    } ev_ent_t;

    // First requesting key at or after p, wrapping modulo N_KEYS. Scanning from
    // the far end downward lets the nearest candidate overwrite the others.
    function automatic logic [KW-1:0] rr_pick(input logic [N_KEYS-1:0] req,
                                              input logic [KW-1:0]     p);
        logic [KW-1:0] pick;
        int            idx;
        pick = '0;
        for (int j = N_KEYS - 1; j >= 0; j--) begin
            idx = (int'(p) + j) % N_KEYS;
            if (req[idx]) pick = KW'(idx);
        end
        return pick;
    endfunction

    logic [N_KEYS-1:0] pend_q;
    logic [N_KEYS-1:0] drop_vec;
    logic [N_KEYS-1:0] gnt_vec;
    logic              gnt_any;
    logic [KW-1:0]     gnt_idx;
    logic              gnt_dbl;
    logic [KW-1:0]     ptr;

    logic [KW-1:0]     last_key;
    logic              last_valid;
    logic [WW-1:0]     win_cnt;
    logic [WW-1:0]     win_inc;

    ev_ent_t           mem [DEPTH];
    ev_ent_t           head;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;
    logic              overflow_q;

    // ---------------- pending latches ----------------
    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        assign gnt_vec[i] = gnt_any && (gnt_idx == KW'(i));

        key_pend_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .flag (key_flag[i]),
            .gnt  (gnt_vec[i]),
            .pend (pend_q[i]),
            .drop (drop_vec[i])
        );
    end

    assign pending = pend_q;

    // ---------------- arbiter ----------------
    // Grant only against the registered count; a same-cycle pop does not free a slot
    always_comb begin
        gnt_any = (|pend_q) && (count < (AW+1)'(DEPTH));
        gnt_idx = rr_pick(pend_q, ptr);
    end

    // Round-robin pointer moves just past the granted key
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (gnt_any)
            ptr <= (gnt_idx == KW'(N_KEYS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // ---------------- double-press detector ----------------
    // win_cnt holds the grant-to-grant distance: it is loaded with 1 on an
    // arming grant, so at the next grant it equals the cycles between the two.
    assign win_inc = (win_cnt == WW'(DBL_CYC)) ? win_cnt : win_cnt + 1'b1;
    assign gnt_dbl = last_valid && (last_key == gnt_idx) && (win_cnt < WW'(DBL_CYC));

    // Arm on a single press, disarm after a double or once the window expires
    always_ff @(posedge clk) begin
        if (rst) begin
            last_key   <= '0;
            last_valid <= 1'b0;
            win_cnt    <= '0;
        end else if (gnt_any && !gnt_dbl) begin
            last_key   <= gnt_idx;
            last_valid <= 1'b1;
            win_cnt    <= WW'(1);
        end else begin
            win_cnt <= win_inc;
            if (gnt_any || (win_inc == WW'(DBL_CYC)))
                last_valid <= 1'b0;
        end
    end

    // ---------------- event FIFO ----------------
    assign push = gnt_any;
    assign pop  = (count != '0) && ev_ready;
    assign head = mem[rd_ptr];

    // Storage needs no reset: the head is only visible while count is non-zero
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{key: gnt_idx, dbl: gnt_dbl};
    end

    // Pointer and occupancy bookkeeping; push+pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign ev_valid = (count != '0);
    assign ev_key   = ev_valid ? head.key : '0;
    assign ev_dbl   = ev_valid ? head.dbl : 1'b0;

    // ---------------- overflow ----------------
    // Sticky drop flag; a new drop beats a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst)            overflow_q <= 1'b0;
        else if (|drop_vec) overflow_q <= 1'b1;
        else if (clr_ovf)   overflow_q <= 1'b0;
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_arb.sv
// tb_key_event_arb: directed scenarios plus randomized traffic, every cycle
// compared against an event-level reference model (queue + grant timestamps).
module tb_key_event_arb;

    localparam int N   = 4;
    localparam int DEP = 4;
    localparam int DBL = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key_flag;
    logic         clr_ovf;
    logic         ev_ready;
    logic         ev_valid;
    logic [1:0]   ev_key;
    logic         ev_dbl;
    logic [N-1:0] pending;
    logic         overflow;

    key_event_arb #(.N_KEYS(N), .DEPTH(DEP), .DBL_CYC(DBL)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_flag (key_flag),
        .clr_ovf  (clr_ovf),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid),
        .ev_key   (ev_key),
        .ev_dbl   (ev_dbl),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int popcnt [N];

    // reference model state
    typedef struct {
        int key;
        bit dbl;
    } mev_t;
    mev_t   mq[$];
    bit [N-1:0] m_pend  = '0;
    int     m_ptr   = 0;
    bit     m_ovf   = 0;
    longint m_cyc   = 0;
    longint m_lastg = 0;
    int     m_lastk = 0;
    bit     m_armed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, m_cyc, got, exp);
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs sampled at that edge
    task automatic model_step();
        bit [N-1:0] gv;
        int k;
        bit d;
        int pre_sz;
        gv = '0;
        k  = 0;
        d  = 0;
        if (rst) begin
            mq.delete();
            m_pend  = '0;
            m_ptr   = 0;
            m_ovf   = 0;
            m_armed = 0;
        end else begin
            pre_sz = mq.size();
            if (m_pend != '0 && pre_sz < DEP) begin
                for (int j = 0; j < N; j++) begin
                    k = (m_ptr + j) % N;
                    if (m_pend[k]) break;
                end
                d = m_armed && (m_lastk == k) && ((m_cyc - m_lastg) < DBL);
                if (d) m_armed = 0;
                else begin
                    m_armed = 1;
                    m_lastk = k;
                    m_lastg = m_cyc;
                end
                gv[k] = 1'b1;
                m_ptr = (k + 1) % N;
            end
            if (pre_sz > 0 && ev_ready) void'(mq.pop_front());
            if (gv != '0) mq.push_back('{key: k, dbl: d});
            if ((key_flag & m_pend & ~gv) != '0) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            m_pend = key_flag | (m_pend & ~gv);
        end
        m_cyc++;
    endtask

    task automatic compare();
        check("ev_valid", 32'(ev_valid), 32'(mq.size() > 0));
        check("ev_key",   32'(ev_key),   (mq.size() > 0) ? 32'(mq[0].key) : 32'd0);
        check("ev_dbl",   32'(ev_dbl),   (mq.size() > 0) ? 32'(mq[0].dbl) : 32'd0);
        check("pending",  32'(pending),  32'(m_pend));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic tick();
        if (ev_valid && ev_ready && !rst) popcnt[ev_key]++;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        key_flag = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [N-1:0] m);
        key_flag = m;
        tick();
        key_flag = '0;
    endtask

    task automatic clr_pops();
        for (int i = 0; i < N; i++) popcnt[i] = 0;
    endtask

    // Press key 1 gap cycles after the previous press, then check the new head
    task automatic press_after(input int gap, input logic exp_dbl, input string tag);
        idle(gap - 2);
        pulse(4'b0010);
        tick();
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check({tag, "_key"},   32'(ev_key),   32'd1);
        check({tag, "_dbl"},   32'(ev_dbl),   32'(exp_dbl));
    endtask

    initial begin
        rst = 1'b1; key_flag = '0; clr_ovf = 1'b0; ev_ready = 1'b1;
        clr_pops();
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid",   32'(ev_valid), 32'd0);
        check("rst_pending", 32'(pending),  32'd0);
        check("rst_ovf",     32'(overflow), 32'd0);

        // single press latency: pend, grant, then visible
        pulse(4'b0100);
        check("lat_pend", 32'(pending), 32'h4);
        tick();
        check("lat_valid", 32'(ev_valid), 32'd1);
        check("lat_key",   32'(ev_key),   32'd2);
        check("lat_dbl",   32'(ev_dbl),   32'd0);
        check("lat_pend0", 32'(pending),  32'd0);
        tick();
        check("lat_once", 32'(ev_valid), 32'd0);

        // all keys at once from ptr=0, drained in order
        rst = 1'b1; tick(); rst = 1'b0;
        ev_ready = 1'b0;
        pulse(4'b1111);
        idle(4);
        for (int j = 0; j < N; j++) begin
            check("rr_valid", 32'(ev_valid), 32'd1);
            check("rr_order", 32'(ev_key),   32'(j));
            ev_ready = 1'b1;
            tick();
        end
        check("rr_empty", 32'(ev_valid), 32'd0);
        check("rr_ovf",   32'(overflow), 32'd0);

        // double-press window
        idle(3);
        pulse(4'b0010);
        tick();
        check("d1_dbl", 32'(ev_dbl), 32'd0);
        press_after(50,  1'b1, "d2");
        press_after(30,  1'b0, "d3");
        press_after(100, 1'b0, "d4");
        press_after(99,  1'b1, "d5");

        // FIFO full: key 3 waits, repeat press is dropped
        ev_ready = 1'b0;
        idle(DBL);
        pulse(4'b0111);
        idle(3);
        pulse(4'b0001);
        idle(1);
        pulse(4'b1000);
        idle(4);
        pulse(4'b1000);
        check("full_pend3", 32'(pending[3]), 32'd1);
        check("full_ovf",   32'(overflow),   32'd1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);
        clr_pops();
        ev_ready = 1'b1;
        idle(10);
        check("key3_once", 32'(popcnt[3]), 32'd1);

        // press landing on its own grant cycle is kept
        clr_pops();
        key_flag = 4'b0001;
        tick();
        tick();
        idle(6);
        check("regrant_cnt", 32'(popcnt[0]), 32'd2);
        check("regrant_ovf", 32'(overflow),  32'd0);

        // reset mid-stream, with presses during the reset cycle
        ev_ready = 1'b0;
        pulse(4'b1111);
        pulse(4'b1111);
        idle(2);
        rst = 1'b1; key_flag = 4'b1111;
        tick();
        rst = 1'b0; key_flag = '0;
        check("mrst_valid", 32'(ev_valid), 32'd0);
        check("mrst_key",   32'(ev_key),   32'd0);
        check("mrst_dbl",   32'(ev_dbl),   32'd0);
        check("mrst_pend",  32'(pending),  32'd0);
        check("mrst_ovf",   32'(overflow), 32'd0);
        idle(2);

        // randomized traffic at a few press densities
        for (int ph = 0; ph < 3; ph++) begin
            int rate;
            rate = (ph == 0) ? 3 : (ph == 1) ? 20 : 80;
            for (int c = 0; c < 1500; c++) begin
                for (int b = 0; b < N; b++)
                    key_flag[b] = ($urandom_range(0, rate - 1) == 0);
                ev_ready = ($urandom_range(0, 3) != 0);
                clr_ovf  = ($urandom_range(0, 49) == 0);
                rst      = ($urandom_range(0, 599) == 0);
                tick();
            end
        end
        rst = 1'b0; key_flag = '0; clr_ovf = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
